// File: rtl/count_stream_monitor.sv
// Receiver for the 4-bit {W,X,Y,Z} board counter bus: synchronise, deglitch,
// track the accepted count and flag illegal steps and tick-period violations.
module count_stream_monitor #(
    parameter int TICK_CYCLES   = 50000000,
    parameter int TOL           = 1000,
    parameter int MAX_COUNT     = 7,
    parameter int STABLE_CYCLES = 4,
    parameter int PW            = 26
) (
    input  logic       PIN_Y2,
    input  logic       KEY_3,
    input  logic       W,
    input  logic       X,
    input  logic       Y,
    input  logic       Z,
    output logic [3:0] value,
    output logic       step_pulse,
    output logic       seq_err,
    output logic       period_err,
    output logic [7:0] err_count,
    output logic       locked
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    localparam int            SW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_N = SW'(STABLE_CYCLES);
    localparam logic [PW-1:0] WIN_LO   = PW'(TICK_CYCLES - TOL);
    localparam logic [PW-1:0] WIN_HI   = PW'(TICK_CYCLES + TOL);
    localparam logic [PW-1:0] STALL_AT = PW'(TICK_CYCLES + TOL + 1);
    localparam logic [3:0]    MAX_V    = 4'(MAX_COUNT);

    logic [3:0]    sync1, sync2, cand;
    logic [SW-1:0] stab_cnt, stab_next;
    logic [PW-1:0] ivl;
    logic [3:0]    succ;
    logic          accept, is_succ, in_win, in_range;
    logic          seq_hit, per_hit;
    state_t        state, nstate;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; blocking here would turn the synchroniser into a wire.
    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            sync1    <= {W, X, Y, Z};
            sync2    <= sync1;
            cand     <= sync2;
            stab_cnt <= stab_next;
        end
    end

    // A run length reaching STABLE_CYCLES with a new value is an accepted change.
    always_comb begin
        if (sync2 == cand)
            stab_next = (stab_cnt == STABLE_N) ? stab_cnt : stab_cnt + 1'b1;
        else
            stab_next = SW'(1);
        accept = (stab_next == STABLE_N) && (sync2 != value);
    end

    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3)
            ivl <= '0;
        else if (accept)
            ivl <= PW'(1);
        else if (ivl != '1)
            ivl <= ivl + 1'b1;
    end

    assign succ     = (value == MAX_V) ? 4'd0 : value + 4'd1;
    assign is_succ  = (sync2 == succ);
    assign in_win   = (ivl >= WIN_LO) && (ivl <= WIN_HI);
    assign in_range = (sync2 <= MAX_V);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        nstate  = state;
        seq_hit = 1'b0;
        per_hit = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    nstate  = ACQUIRE;
                    seq_hit = !in_range;
                end
                ACQUIRE: begin
                    if (!in_range)
                        seq_hit = 1'b1;
                    else if (is_succ && in_win)
                        nstate = TRACK;
                    else if (!is_succ && sync2 != 4'd0)
                        seq_hit = 1'b1;
                end
                TRACK: begin
                    nstate = ACQUIRE;
                    if (!in_range)
                        seq_hit = 1'b1;
                    else if (is_succ && in_win)
                        nstate = TRACK;
                    else if (is_succ)
                        per_hit = 1'b1;
                    else if (sync2 != 4'd0)
                        seq_hit = 1'b1;
                end
                default: nstate = IDLE;
            endcase
        end else if (state == TRACK && ivl == STALL_AT) begin
            // Stall: leaving TRACK guarantees a single pulse until the next change.
            per_hit = 1'b1;
            nstate  = ACQUIRE;
        end
    end

    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3) begin
            state      <= IDLE;
            value      <= '0;
            step_pulse <= 1'b0;
            seq_err    <= 1'b0;
            period_err <= 1'b0;
            err_count  <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= nstate;
            step_pulse <= accept;
            seq_err    <= seq_hit;
            period_err <= per_hit;
            locked     <= (nstate == TRACK);
            if (accept)
                value <= sync2;
            if ((seq_hit || per_hit) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed bench for count_stream_monitor with a short tick period so that
// locking, step errors, stalls, deglitching and saturation are all reachable.
module tb_count_stream_monitor;

    logic       PIN_Y2 = 1'b0;
    logic       KEY_3;
    logic [3:0] bus;
    logic [3:0] value;
    logic       step_pulse, seq_err, period_err, locked;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    count_stream_monitor #(
        .TICK_CYCLES(20), .TOL(2), .MAX_COUNT(7), .STABLE_CYCLES(4), .PW(26)
    ) dut (
        .PIN_Y2(PIN_Y2), .KEY_3(KEY_3),
        .W(bus[3]), .X(bus[2]), .Y(bus[1]), .Z(bus[0]),
        .value(value), .step_pulse(step_pulse), .seq_err(seq_err),
        .period_err(period_err), .err_count(err_count), .locked(locked)
    );

    always #5 PIN_Y2 = ~PIN_Y2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Change the bus gap cycles after the previous change, then verify the
    // step lands exactly 6 edges after the first sampling edge.
    task automatic step(input logic [3:0] v, input int gap,
                        input logic exp_seq, input logic exp_per, input logic exp_lock);
        repeat (gap - 6) @(posedge PIN_Y2);
        @(negedge PIN_Y2);
        bus = v;
        repeat (5) @(posedge PIN_Y2);
        #1;
        check($sformatf("early_step_v%0d", v), 32'(step_pulse), 32'd0);
        @(posedge PIN_Y2);
        #1;
        check($sformatf("step_pulse_v%0d", v), 32'(step_pulse), 32'd1);
        check($sformatf("value_v%0d", v), 32'(value), 32'(v));
        check($sformatf("seq_err_v%0d", v), 32'(seq_err), 32'(exp_seq));
        check($sformatf("period_err_v%0d", v), 32'(period_err), 32'(exp_per));
        check($sformatf("locked_v%0d", v), 32'(locked), 32'(exp_lock));
    endtask

    // Drive v for hold cycles then return to base; observe 12 edges.
    task automatic pulse(input logic [3:0] v, input int hold, input logic [3:0] base,
                         output int steps, output int first_edge,
                         output logic [3:0] first_val, output int seqs);
        steps = 0; first_edge = 0; first_val = '0; seqs = 0;
        @(negedge PIN_Y2);
        bus = v;
        for (int i = 1; i <= 12; i++) begin
            @(posedge PIN_Y2);
            #1;
            if (step_pulse) begin
                if (steps == 0) begin
                    first_edge = i;
                    first_val  = value;
                end
                steps++;
            end
            if (seq_err) seqs++;
            if (i == hold) begin
                @(negedge PIN_Y2);
                bus = base;
            end
        end
    endtask

    initial begin
        int         steps, first_edge, seqs, per_cnt, per_edge;
        logic [3:0] first_val;

        KEY_3 = 1'b0;
        bus   = 4'd0;
        #12;
        check("rst_value", 32'(value), 32'd0);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_seq", 32'(seq_err), 32'd0);
        check("rst_per", 32'(period_err), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        @(negedge PIN_Y2);
        KEY_3 = 1'b1;
        repeat (3) @(posedge PIN_Y2);
        #1;

        // Clean counting with wrap; lock on the second accepted step.
        step(4'd1, 6, 1'b0, 1'b0, 1'b0);
        for (int v = 2; v <= 8; v++)
            step(4'(v % 8), 20, 1'b0, 1'b0, 1'b1);
        step(4'd1, 20, 1'b0, 1'b0, 1'b1);
        check("t1_err", 32'(err_count), 32'd0);

        // Illegal jump 3 -> 5, then relock.
        step(4'd2, 20, 1'b0, 1'b0, 1'b1);
        step(4'd3, 20, 1'b0, 1'b0, 1'b1);
        step(4'd5, 20, 1'b1, 1'b0, 1'b0);
        check("t2_err", 32'(err_count), 32'd1);
        step(4'd6, 20, 1'b0, 1'b0, 1'b1);
        step(4'd7, 20, 1'b0, 1'b0, 1'b1);

        // Window edges: 17 is short, 18 and 22 are inside.
        step(4'd0, 17, 1'b0, 1'b1, 1'b0);
        check("t3_err", 32'(err_count), 32'd2);
        step(4'd1, 20, 1'b0, 1'b0, 1'b1);
        step(4'd2, 18, 1'b0, 1'b0, 1'b1);
        step(4'd3, 22, 1'b0, 1'b0, 1'b1);
        check("t3_err_hold", 32'(err_count), 32'd2);

        // Stall at 4: one period_err when the interval reaches 23.
        step(4'd4, 20, 1'b0, 1'b0, 1'b1);
        per_cnt = 0; per_edge = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge PIN_Y2);
            #1;
            if (period_err) begin
                per_cnt++;
                per_edge = i;
            end
        end
        check("t4_stall_count", 32'(per_cnt), 32'd1);
        check("t4_stall_edge", 32'(per_edge), 32'd23);
        check("t4_locked", 32'(locked), 32'd0);
        check("t4_err", 32'(err_count), 32'd3);
        step(4'd0, 6, 1'b0, 1'b0, 1'b0);
        check("t4_err_clear", 32'(err_count), 32'd3);

        // Successors outside the window keep ACQUIRE silently.
        step(4'd1, 30, 1'b0, 1'b0, 1'b0);
        step(4'd2, 30, 1'b0, 1'b0, 1'b0);

        // 3-cycle glitch rejected, 4-cycle pulse accepted both ways.
        pulse(4'd6, 3, 4'd2, steps, first_edge, first_val, seqs);
        check("t5_glitch_steps", 32'(steps), 32'd0);
        check("t5_glitch_seq", 32'(seqs), 32'd0);
        check("t5_glitch_value", 32'(value), 32'd2);
        pulse(4'd6, 4, 4'd2, steps, first_edge, first_val, seqs);
        check("t5_pulse_steps", 32'(steps), 32'd2);
        check("t5_pulse_edge", 32'(first_edge), 32'd6);
        check("t5_pulse_value", 32'(first_val), 32'd6);
        check("t5_pulse_seq", 32'(seqs), 32'd2);
        check("t5_err", 32'(err_count), 32'd5);

        // 300 pairs of 0/9: only the 9s are errors, tally must stick at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge PIN_Y2);
            bus = 4'd0;
            repeat (6) @(posedge PIN_Y2);
            @(negedge PIN_Y2);
            bus = 4'd9;
            repeat (6) @(posedge PIN_Y2);
            #1;
            if (i == 0)
                check("t6_first_err", 32'(err_count), 32'd6);
        end
        check("t6_sat", 32'(err_count), 32'd255);
        check("t6_value", 32'(value), 32'd9);

        // Asynchronous reset with a change in flight.
        @(negedge PIN_Y2);
        bus = 4'd0;
        repeat (2) @(posedge PIN_Y2);
        #3;
        KEY_3 = 1'b0;
        #1;
        check("t6_rst_value", 32'(value), 32'd0);
        check("t6_rst_err", 32'(err_count), 32'd0);
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_flags", 32'({step_pulse, seq_err, period_err}), 32'd0);
        @(negedge PIN_Y2);
        KEY_3 = 1'b1;
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge PIN_Y2);
            #1;
            if (step_pulse) steps++;
        end
        check("t6_post_steps", 32'(steps), 32'd0);
        check("t6_post_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_stream_monitor.md
Name: count_stream_monitor

Overview:
- Receiving end of the 4-bit board counter bus {W,X,Y,Z}. The counter side steps 0..MAX_COUNT once per tick and wraps to 0.
- This block synchronises and deglitches the bus, tracks the accepted count, and checks two things: each step is the legal successor, and the step interval matches the tick period.
- Reports step pulses, a lock status and a saturating error tally for LEDs/display on the same board.

Parameters:
TICK_CYCLES, 50000000, expected clock cycles between consecutive count steps
TOL, 1000, allowed deviation in cycles from TICK_CYCLES (inclusive)
MAX_COUNT, 7, highest legal count before wrap to 0
STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a value (>=1)
PW, 26, interval counter width; must hold TICK_CYCLES+TOL+1

Ports:
PIN_Y2  input  1  system clock, rising edge
KEY_3  input  1  reset; active-low asynchronous reset, single clock domain PIN_Y2
W  input  1  count bit 3 (MSB), asynchronous to PIN_Y2
X  input  1  count bit 2
Y  input  1  count bit 1
Z  input  1  count bit 0 (LSB)
value  output  4  last accepted count
step_pulse  output  1  one-cycle pulse when value updates
seq_err  output  1  one-cycle pulse: illegal step or out-of-range value
period_err  output  1  one-cycle pulse: interval outside window or stall
err_count  output  8  saturating error event count
locked  output  1  high while state==TRACK

Behaviour:
- Reset (KEY_3=0, async):
  - value=0, step_pulse=0, seq_err=0, period_err=0, err_count=0, locked=0.
  - state=IDLE, synchroniser and stability counters cleared, interval counter=0.
- Input path:
  - 2-flop synchroniser on {W,X,Y,Z}.
  - Stability counter counts consecutive identical synchronised samples; it restarts on any difference.
  - A sample is accepted when it has been stable STABLE_CYCLES cycles and differs from value.
  - Fixed latency: a clean input change is reflected in value/step_pulse exactly STABLE_CYCLES+2 rising edges after the first edge that samples it.
  - Glitches shorter than STABLE_CYCLES cycles: no effect.
- Interval counter:
  - Increments every cycle, saturates at 2^PW-1.
  - Loads 1 on the cycle of an accepted change; the interval is its value just before reload.
- Window: TICK_CYCLES-TOL <= interval <= TICK_CYCLES+TOL.
- Successor: (value==MAX_COUNT) ? 0 : value+1.
- State IDLE (no checks):
  - First accepted change in range -> ACQUIRE, no error.
  - Accepted value > MAX_COUNT -> seq_err, ACQUIRE.
- State ACQUIRE:
  - Successor inside window -> TRACK.
  - Successor outside window -> stay, no error.
  - 0 that is not the successor (clear) -> stay, no error.
  - Value > MAX_COUNT or any other non-successor -> seq_err, stay.
- State TRACK:
  - Successor inside window -> stay.
  - Successor outside window -> period_err, ACQUIRE.
  - Non-successor 0 (clear) -> ACQUIRE, no error.
  - Any other value -> seq_err, ACQUIRE.
  - Stall: interval counter reaches TICK_CYCLES+TOL+1 with no change -> period_err once, ACQUIRE. No repeat until the next change.
- Every accepted change updates value and pulses step_pulse, legal or not.
- Error pulses are registered and coincide with step_pulse, except a stall pulse, which has no step_pulse.
- err_count:
  - +1 per cycle in which seq_err or period_err is high.
  - Both high in the same cycle counts once.
  - Holds at 255.
- locked is registered and reflects state after the transition.
- Reset mid-operation: immediate return to reset values regardless of state or in-flight samples.

Test Plan:
Sim parameters: TICK_CYCLES=20, TOL=2, STABLE_CYCLES=4.
1. Release reset, drive 1,2,3,...,7,0,1 every 20 cycles, clean edges -> step_pulse exactly 6 edges after each change; locked rises at the second accepted step and stays 1 through the wrap 7->0; err_count=0.
2. Locked at value 3; drive 5 -> seq_err one cycle with step_pulse, value=5, locked=0, err_count=1. Then 6 at 20 and 7 at 40 cycles later -> locked=1 again.
3. Locked; next step arrives after 17 cycles -> period_err, locked=0. Repeat with the step at 18 and at 22 cycles -> no error, stays locked.
4. Locked at 4; hold the bus for 40 cycles -> single period_err at interval 23, locked=0, err_count+1; no second pulse. Then drive 0 -> no error, state ACQUIRE.
5. Stable bus at 2; inject 3-cycle glitch to 6 -> no step_pulse, no error. Inject 4-cycle pulse -> accepted (value=6, seq_err).
6. Force 300 alternating 0/9 values -> err_count saturates at 255. Assert KEY_3 low mid-stream, asynchronous to the clock -> all outputs 0 before the next edge.
